// File: rtl/sad_search_ctrl_if.sv
// Datapath-side bus of the SAD search sequencer: geometry/opcode/address outputs and the SAD return.
// SAD_valid qualifies SAD_in for one cycle; the controller is always ready while in WAIT and ignores it elsewhere.
interface sad_search_ctrl_if;
  logic [31:0] MemAddress;
  logic [31:0] WindowAddress;
  logic [31:0] Width;
  logic [31:0] Height;
  logic [5:0]  ALUOp;
  logic        SADOp;
  logic [31:0] SAD_in;
  logic        SAD_valid;

  modport master (
    output MemAddress, WindowAddress, Width, Height, ALUOp, SADOp,
    input  SAD_in, SAD_valid
  );

  modport slave (
    input  MemAddress, WindowAddress, Width, Height, ALUOp, SADOp,
    output SAD_in, SAD_valid
  );
endinterface

// File: rtl/sad_search_ctrl.sv
// SAD search sequencer: configures the SAD datapath, walks every window position in raster order and
// keeps the minimum SAD. Define SAD_WAIT_TIMEOUT_EN to abort a search after 256 idle WAIT cycles.
module sad_search_ctrl #(
  parameter int DIM_W = 16
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [31:0]        FrameBase,
  input  logic [DIM_W-1:0]   FrameWidth,
  input  logic [DIM_W-1:0]   FrameHeight,
  input  logic [DIM_W-1:0]   WinWidth,
  input  logic [DIM_W-1:0]   WinHeight,
  sad_search_ctrl_if.master  dp,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [31:0]        BestSAD,
  output logic [DIM_W-1:0]   BestX,
  output logic [DIM_W-1:0]   BestY,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_WIN, S_CFG_FRAME, S_RUN, S_WAIT, S_NEXT, S_DONE
  } state_t;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [DIM_W-1:0] fw_q, fw_d, fh_q, fh_d, ww_q, ww_d, wh_q, wh_d;
  logic [DIM_W-1:0] x_q, x_d, y_q, y_d, c_q, c_d, r_q, r_d;
  logic [31:0]      mem_q, mem_d, win_q, win_d, width_q, width_d, height_q, height_d;
  logic [5:0]       aluop_q, aluop_d;
  logic             sadop_q, sadop_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]      best_sad_q, best_sad_d;
  logic [DIM_W-1:0] best_x_q, best_x_d, best_y_q, best_y_d;
`ifdef SAD_WAIT_TIMEOUT_EN
  logic [7:0]       tmo_q, tmo_d;
`endif

  logic        bad_geom, x_last, y_last;
  logic [31:0] mem_off, win_off;

  assign bad_geom = (FrameWidth == '0) || (FrameHeight == '0) || (WinWidth == '0) ||
                    (WinHeight == '0) || (WinWidth > FrameWidth) || (WinHeight > FrameHeight);
  assign x_last   = (x_q == fw_q - ww_q);
  assign y_last   = (y_q == fh_q - wh_q);
  // Word offsets from the frame origin; all arithmetic wraps at 32 bits.
  assign mem_off  = (32'(y_q) + 32'(r_q)) * 32'(fw_q) + 32'(x_q) + 32'(c_q);
  assign win_off  = 32'(y_q) * 32'(fw_q) + 32'(x_q);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    fw_d       = fw_q;
    fh_d       = fh_q;
    ww_d       = ww_q;
    wh_d       = wh_q;
    x_d        = x_q;
    y_d        = y_q;
    c_d        = c_q;
    r_d        = r_q;
    busy_d     = busy_q;
    err_d      = err_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    mem_d      = '0;
    win_d      = '0;
    width_d    = '0;
    height_d   = '0;
    aluop_d    = '0;
    sadop_d    = 1'b0;
    done_d     = 1'b0;
`ifdef SAD_WAIT_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          base_d     = FrameBase;
          fw_d       = FrameWidth;
          fh_d       = FrameHeight;
          ww_d       = WinWidth;
          wh_d       = WinHeight;
          x_d        = '0;
          y_d        = '0;
          c_d        = '0;
          r_d        = '0;
          busy_d     = 1'b1;
          err_d      = 1'b0;
          best_sad_d = 32'hFFFF_FFFF;
          best_x_d   = '0;
          best_y_d   = '0;
          if (bad_geom) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CFG_WIN;
          end
        end
      end
      S_CFG_WIN: begin
        aluop_d  = 6'b111110;
        width_d  = 32'(ww_q);
        height_d = 32'(wh_q);
        sadop_d  = 1'b1;
        state_d  = S_CFG_FRAME;
      end
      S_CFG_FRAME: begin
        aluop_d = 6'b111100;
        width_d = 32'(fw_q);
        sadop_d = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        aluop_d = 6'b111111;
        sadop_d = 1'b1;
        mem_d   = base_q + (mem_off << 2);
        win_d   = base_q + (win_off << 2);
        if (c_q == ww_q - ONE) begin
          c_d = '0;
          if (r_q == wh_q - ONE) begin
            r_d     = '0;
            state_d = S_WAIT;
`ifdef SAD_WAIT_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            r_d = r_q + ONE;
          end
        end else begin
          c_d = c_q + ONE;
        end
      end
      S_WAIT: begin
        if (dp.SAD_valid) begin
          // Strict compare: on a tie the earlier raster position stays the winner.
          if (dp.SAD_in < best_sad_q) begin
            best_sad_d = dp.SAD_in;
            best_x_d   = x_q;
            best_y_d   = y_q;
          end
          state_d = S_NEXT;
`ifdef SAD_WAIT_TIMEOUT_EN
        end else if (tmo_q == 8'hFF) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
`endif
        end
      end
      S_NEXT: begin
        if (x_last) begin
          x_d = '0;
          if (y_last) begin
            state_d = S_DONE;
          end else begin
            y_d     = y_q + ONE;
            state_d = S_RUN;
          end
        end else begin
          x_d     = x_q + ONE;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      fw_q       <= '0;
      fh_q       <= '0;
      ww_q       <= '0;
      wh_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      c_q        <= '0;
      r_q        <= '0;
      mem_q      <= '0;
      win_q      <= '0;
      width_q    <= '0;
      height_q   <= '0;
      aluop_q    <= '0;
      sadop_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      best_sad_q <= 32'hFFFF_FFFF;
      best_x_q   <= '0;
      best_y_q   <= '0;
`ifdef SAD_WAIT_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      fw_q       <= fw_d;
      fh_q       <= fh_d;
      ww_q       <= ww_d;
      wh_q       <= wh_d;
      x_q        <= x_d;
      y_q        <= y_d;
      c_q        <= c_d;
      r_q        <= r_d;
      mem_q      <= mem_d;
      win_q      <= win_d;
      width_q    <= width_d;
      height_q   <= height_d;
      aluop_q    <= aluop_d;
      sadop_q    <= sadop_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
`ifdef SAD_WAIT_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign dp.MemAddress    = mem_q;
  assign dp.WindowAddress = win_q;
  assign dp.Width         = width_q;
  assign dp.Height        = height_q;
  assign dp.ALUOp         = aluop_q;
  assign dp.SADOp         = sadop_q;
  assign Busy             = busy_q;
  assign Done             = done_q;
  assign Err              = err_q;
  assign BestSAD          = best_sad_q;
  assign BestX            = best_x_q;
  assign BestY            = best_y_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Directed bench for sad_search_ctrl: a spec-level model predicts every datapath cycle, the search
// result and the cycle count; a responder plays the SAD datapath with a configurable latency.
module tb_sad_search_ctrl;
  localparam int DIM_W = 16;
  localparam int EW    = 135;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             Start = 1'b0;
  logic [31:0]      FrameBase = '0;
  logic [DIM_W-1:0] FrameWidth = '0, FrameHeight = '0, WinWidth = '0, WinHeight = '0;
  logic             Busy, Done, Err;
  logic [31:0]      BestSAD;
  logic [DIM_W-1:0] BestX, BestY;
  logic [2:0]       dbg_state;

  sad_search_ctrl_if dp();

  sad_search_ctrl #(.DIM_W(DIM_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .FrameBase(FrameBase),
    .FrameWidth(FrameWidth), .FrameHeight(FrameHeight),
    .WinWidth(WinWidth), .WinHeight(WinHeight), .dp(dp),
    .Busy(Busy), .Done(Done), .Err(Err), .BestSAD(BestSAD),
    .BestX(BestX), .BestY(BestY), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of test, required finish before 3 ms");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] msk_q[$];
  logic [31:0]   cap_mem[$];
  logic [31:0]   sad_tab[$];
  int done_cnt = 0;
  int cand = 0;
  int lat = 1;
  bit resp_en = 1'b1;
  int run_cnt = 0;
  int cur_ww = 1, cur_wh = 1;
  logic [EW-1:0] act_v, e_v, m_v;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- spec-level model ----------------
  task automatic push_expected(input logic [31:0] base, input int fw, input int fh,
                               input int ww, input int wh);
    logic [31:0] mem, win;
    exp_q.push_back({6'b111110, 1'b1, 32'(ww), 32'(wh), 64'h0});
    msk_q.push_back({6'h3F, 1'b1, {64{1'b1}}, 64'h0});
    exp_q.push_back({6'b111100, 1'b1, 32'(fw), 32'h0, 64'h0});
    msk_q.push_back({6'h3F, 1'b1, {32{1'b1}}, 32'h0, 64'h0});
    for (int y = 0; y <= fh - wh; y++)
      for (int x = 0; x <= fw - ww; x++)
        for (int r = 0; r < wh; r++)
          for (int c = 0; c < ww; c++) begin
            mem = base + 32'((((y + r) * fw) + x + c) * 4);
            win = base + 32'(((y * fw) + x) * 4);
            exp_q.push_back({6'b111111, 1'b1, 64'h0, mem, win});
            msk_q.push_back({6'h3F, 1'b1, 64'h0, {64{1'b1}}});
          end
  endtask

  task automatic model_best(input int fw, input int fh, input int ww, input int wh,
                            output logic [31:0] b, output int bx, output int by);
    int nx, n;
    logic [31:0] v;
    nx = fw - ww + 1;
    n  = nx * (fh - wh + 1);
    b = 32'hFFFF_FFFF; bx = 0; by = 0;
    for (int i = 0; i < n; i++) begin
      v = (i < sad_tab.size()) ? sad_tab[i] : 32'hDEAD;
      if (v < b) begin b = v; bx = i % nx; by = i / nx; end
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge Clk) begin
    if (Rst_n) begin
      if (Done) done_cnt++;
      if (dp.ALUOp != 6'd0 || dp.SADOp) begin
        act_v = {dp.ALUOp, dp.SADOp, dp.Width, dp.Height, dp.MemAddress, dp.WindowAddress};
        if (dp.ALUOp == 6'b111111) cap_mem.push_back(dp.MemAddress);
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL dp_cycle: got %0h required no datapath activity", act_v);
        end else begin
          e_v = exp_q.pop_front();
          m_v = msk_q.pop_front();
          if ((act_v & m_v) !== (e_v & m_v)) begin
            bad++;
            $display("FAIL dp_cycle: got %0h required %0h (mask %0h)", act_v, e_v, m_v);
          end
        end
      end
    end
  end

  // ---------------- datapath responder ----------------
  always begin
    @(negedge Clk);
    if (!Rst_n || dp.ALUOp == 6'b111110) begin
      run_cnt = 0;
    end else if (dp.ALUOp == 6'b111111) begin
      run_cnt++;
      if (run_cnt == cur_ww * cur_wh) begin
        run_cnt = 0;
        if (resp_en) begin
          repeat (lat) @(negedge Clk);
          dp.SAD_in    = (cand < sad_tab.size()) ? sad_tab[cand] : 32'hDEAD;
          dp.SAD_valid = 1'b1;
          cand++;
          @(negedge Clk);
          dp.SAD_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_pulse(input logic [31:0] base, input int fw, input int fh,
                             input int ww, input int wh);
    cur_ww = ww; cur_wh = wh; cand = 0;
    @(negedge Clk);
    FrameBase = base;
    FrameWidth = DIM_W'(fw); FrameHeight = DIM_W'(fh);
    WinWidth = DIM_W'(ww);   WinHeight = DIM_W'(wh);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic run_search(input logic [31:0] base, input int fw, input int fh,
                            input int ww, input int wh, input string tag);
    bit ok;
    int k, exp_k, d0, ebx, eby;
    logic [31:0] ebs;
    ok = (fw > 0) && (fh > 0) && (ww > 0) && (wh > 0) && (ww <= fw) && (wh <= fh);
    cap_mem.delete();
    if (ok) begin
      push_expected(base, fw, fh, ww, wh);
      model_best(fw, fh, ww, wh, ebs, ebx, eby);
      exp_k = 2 + (fw - ww + 1) * (fh - wh + 1) * (ww * wh + lat + 2) + 1 + 1;
    end else begin
      ebs = 32'hFFFF_FFFF; ebx = 0; eby = 0;
      exp_k = 2;
    end
    d0 = done_cnt;
    start_pulse(base, fw, fh, ww, wh);
    k = 1;
    check({tag, "_busy"}, 128'(Busy), 128'(1));
    while (!Done && k < 5000) begin
      @(negedge Clk);
      k++;
    end
    check({tag, "_cycles"}, 128'(k), 128'(exp_k));
    check({tag, "_err"}, 128'(Err), 128'(!ok));
    check({tag, "_best_sad"}, 128'(BestSAD), 128'(ebs));
    check({tag, "_best_x"}, 128'(BestX), 128'(ebx));
    check({tag, "_best_y"}, 128'(BestY), 128'(eby));
    check({tag, "_busy_end"}, 128'(Busy), 128'(0));
    repeat (3) @(negedge Clk);
    check({tag, "_done_once"}, 128'(done_cnt - d0), 128'(1));
    check({tag, "_exp_drained"}, 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k, d0;
    dp.SAD_in = '0;
    dp.SAD_valid = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_mem", 128'(dp.MemAddress), 128'(0));
    check("rst_win", 128'(dp.WindowAddress), 128'(0));
    check("rst_width", 128'(dp.Width), 128'(0));
    check("rst_height", 128'(dp.Height), 128'(0));
    check("rst_aluop", 128'(dp.ALUOp), 128'(0));
    check("rst_sadop", 128'(dp.SADOp), 128'(0));
    check("rst_busy", 128'(Busy), 128'(0));
    check("rst_done", 128'(Done), 128'(0));
    check("rst_err", 128'(Err), 128'(0));
    check("rst_best_sad", 128'(BestSAD), 128'(32'hFFFF_FFFF));
    check("rst_best_x", 128'(BestX), 128'(0));
    check("rst_best_y", 128'(BestY), 128'(0));
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // 4x4 frame, 2x2 window: config sequence, address stream and tie handling
    sad_tab = '{32'd50, 32'd40, 32'd40, 32'd30, 32'd60, 32'd30, 32'd70, 32'd80, 32'd90};
    lat = 1;
    run_search(32'h100, 4, 4, 2, 2, "full");
    check("lit_mem0", 128'(cap_mem[0]), 128'(32'h100));
    check("lit_mem1", 128'(cap_mem[1]), 128'(32'h104));
    check("lit_mem2", 128'(cap_mem[2]), 128'(32'h110));
    check("lit_mem3", 128'(cap_mem[3]), 128'(32'h114));
    check("lit_best_sad", 128'(BestSAD), 128'(30));
    check("lit_best_x", 128'(BestX), 128'(0));
    check("lit_best_y", 128'(BestY), 128'(1));

    // invalid geometries
    run_search(32'h100, 4, 4, 5, 2, "inv_wide");
    check("inv_no_mem", 128'(cap_mem.size()), 128'(0));
    run_search(32'h200, 4, 0, 1, 1, "inv_zero");

    // back-pressure plus a Start while Busy; Err from the previous search must clear
    lat = 10;
    fork
      begin
        repeat (30) @(negedge Clk);
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
      end
    join_none
    run_search(32'h100, 4, 4, 2, 2, "bp");
    check("bp_lit_best_sad", 128'(BestSAD), 128'(30));
    lat = 1;

    // window equals frame, base wraps past 2^32
    sad_tab = '{32'd7};
    run_search(32'hFFFF_FFF0, 3, 2, 3, 2, "single");

    // 1x1 window, ties on the minimum keep the first position
    sad_tab = '{32'd9, 32'd4, 32'd6, 32'd4, 32'd8, 32'd4};
    run_search(32'h40, 3, 2, 1, 1, "tie");
    check("tie_lit_x", 128'(BestX), 128'(1));
    check("tie_lit_y", 128'(BestY), 128'(0));

    // SAD equal to the initial best never replaces it
    sad_tab = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_search(32'h0, 2, 1, 1, 1, "allmax");

    // reset in the middle of RUN
    sad_tab = '{32'd50, 32'd40, 32'd40, 32'd30, 32'd60, 32'd30, 32'd70, 32'd80, 32'd90};
    cap_mem.delete();
    push_expected(32'h100, 4, 4, 2, 2);
    start_pulse(32'h100, 4, 4, 2, 2);
    k = 0;
    while (cap_mem.size() < 14 && k < 300) begin
      @(negedge Clk);
      k++;
    end
    check("mid_reached_run", 128'(dp.ALUOp), 128'(6'b111111));
    d0 = done_cnt;
    Rst_n = 1'b0;
    #1;
    check("mid_rst_mem", 128'(dp.MemAddress), 128'(0));
    check("mid_rst_win", 128'(dp.WindowAddress), 128'(0));
    check("mid_rst_aluop", 128'(dp.ALUOp), 128'(0));
    check("mid_rst_sadop", 128'(dp.SADOp), 128'(0));
    check("mid_rst_busy", 128'(Busy), 128'(0));
    check("mid_rst_best_sad", 128'(BestSAD), 128'(32'hFFFF_FFFF));
    check("mid_rst_best_y", 128'(BestY), 128'(0));
    repeat (3) @(negedge Clk);
    check("mid_rst_no_done", 128'(Done), 128'(0));
    exp_q.delete();
    msk_q.delete();
    Rst_n = 1'b1;
    repeat (4) @(negedge Clk);
    check("mid_rst_done_cnt", 128'(done_cnt - d0), 128'(0));

    // datapath never answers
    resp_en = 1'b0;
    cap_mem.delete();
    push_expected(32'h100, 2, 2, 2, 2);
    d0 = done_cnt;
    start_pulse(32'h100, 2, 2, 2, 2);
    k = 1;
`ifdef SAD_WAIT_TIMEOUT_EN
    while (!Done && k < 600) begin
      @(negedge Clk);
      k++;
    end
    check("tmo_cycles", 128'(k), 128'(2 + 4 + 256 + 1 + 1));
    check("tmo_err", 128'(Err), 128'(1));
    check("tmo_best_sad", 128'(BestSAD), 128'(32'hFFFF_FFFF));
    repeat (3) @(negedge Clk);
    check("tmo_done_once", 128'(done_cnt - d0), 128'(1));
`else
    repeat (400) @(negedge Clk);
    check("hang_no_done", 128'(done_cnt - d0), 128'(0));
    check("hang_busy", 128'(Busy), 128'(1));
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
`endif
    check("hang_exp_drained", 128'(exp_q.size()), 128'(0));
    resp_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Sequencer for the SAD datapath (`top`): configures window and frame geometry through the ALUOp configuration codes, then walks every candidate window position across a frame in raster order. For each position it streams word addresses to the datapath and captures the returned SAD, keeping the minimum and its (x, y) position. It sits between the system-level start/result registers and the SAD unit's `MemAddress`/`WindowAddress`/`Width`/`Height`/`ALUOp`/`SADOp` inputs.

## Interface
- `DIM_W`, default 16: width of frame/window dimension inputs and position counters.
- `Clk`  in  1  — single clock; all state updates on the rising edge.
- `Rst_n`  in  1  — asynchronous, active-low reset.
- `Start`  in  1  — begin a search; sampled only in IDLE.
- `FrameBase`  in  32  — byte address of frame pixel (0,0).
- `FrameWidth`, `FrameHeight`  in  DIM_W  — frame size in words.
- `WinWidth`, `WinHeight`  in  DIM_W  — window size in words.
- `MemAddress`, `WindowAddress`  out  32  — datapath address buses.
- `Width`, `Height`  out  32  — datapath geometry buses, zero-extended.
- `ALUOp`  out  6  — datapath opcode.
- `SADOp`  out  1  — SAD enable.
- `SAD_in`  in  32  — SAD result from the datapath.
- `SAD_valid`  in  1  — `SAD_in` valid this cycle.
- `Busy`  out  1  — high from the cycle after Start until Done.
- `Done`  out  1  — one-cycle pulse at the end of a search.
- `Err`  out  1  — held high after an invalid or aborted search; cleared by the next Start.
- `BestSAD`  out  32  — minimum SAD found.
- `BestX`, `BestY`  out  DIM_W  — position of the minimum.

## Operation
- States: IDLE, CFG_WIN, CFG_FRAME, RUN, WAIT, NEXT, DONE.
- IDLE: `Start` latches all inputs, clears `Err`, sets `BestSAD`=32'hFFFFFFFF and `BestX`/`BestY`=0, and sets x=y=0.
  - If any dimension is 0, or WinWidth>FrameWidth, or WinHeight>FrameHeight, go to DONE with `Err`=1.
  - Otherwise go to CFG_WIN.
- CFG_WIN (1 cycle): `ALUOp`=6'b111110, `Width`=WinWidth, `Height`=WinHeight, `SADOp`=1.
- CFG_FRAME (1 cycle): `ALUOp`=6'b111100, `Width`=FrameWidth, `SADOp`=1.
- RUN (WinWidth×WinHeight cycles): `ALUOp`=6'b111111, `SADOp`=1.
  - `WindowAddress` = FrameBase + 4·(y·FrameWidth + x).
  - `MemAddress` = FrameBase + 4·((y+r)·FrameWidth + x + c); column c advances each cycle and wraps to 0 with r+1 at WinWidth.
- WAIT: `ALUOp`=0, `SADOp`=0; remain until `SAD_valid`.
  - If `SAD_in` < `BestSAD` (strict), register `SAD_in`, x, y into the Best outputs. Ties keep the earlier position.
  - Next state is NEXT.
- NEXT (1 cycle): x+1; when x = FrameWidth−WinWidth, wrap x to 0 and increment y.
  - After the last position (x=FrameWidth−WinWidth, y=FrameHeight−WinHeight), go to DONE; otherwise go to RUN.
- DONE (1 cycle): `Done`=1, then return to IDLE. Best outputs hold until the next Start.
- `SAD_valid` outside WAIT is ignored. `Start` outside IDLE is ignored.
- Address arithmetic is modulo 2^32. Products use 32-bit intermediates.

## Timing
- Reset values: `MemAddress`, `WindowAddress`, `Width`, `Height`, `ALUOp`, `SADOp`, `Busy`, `Done`, `Err` = 0; `BestSAD`=32'hFFFFFFFF; `BestX`/`BestY`=0; state=IDLE.
- Reset asserted mid-search: immediate return to IDLE with the reset values above; no `Done` pulse.
- All outputs are registered. Start seen at edge N gives CFG_WIN outputs after edge N+1.
- Per candidate: W·H (RUN) + datapath latency (WAIT, ≥1) + 1 (NEXT) cycles.
- Search total: 2 + Σ per-candidate cycles + 1 (DONE).
- `SAD_valid` in the same cycle as entering WAIT is not possible. The earliest accepted `SAD_valid` is the first WAIT cycle.

## Configuration
- `SAD_WAIT_TIMEOUT_EN` defined: an 8-bit counter runs in WAIT. If 256 cycles pass without `SAD_valid`, go to DONE with `Err`=1, keeping the Best values found so far.
- `SAD_WAIT_TIMEOUT_EN` undefined: WAIT blocks indefinitely and there is no counter logic.

## Test plan
- Reset: hold `Rst_n`=0 mid-RUN -> all outputs at reset values asynchronously; `BestSAD`=FFFFFFFF; no `Done`.
- Config sequence: Frame 4×4, Win 2×2, FrameBase=0x100 -> `ALUOp` 111110 (Width=2, Height=2), then 111100 (Width=4), then 111111 for 4 cycles with `MemAddress` 0x100, 0x104, 0x110, 0x114.
- Full search, same geometry: 9 candidates; model returns SADs 50,40,40,30,60,30,70,80,90 -> `BestSAD`=30, `BestX`=0, `BestY`=1 (tie keeps first); one `Done` pulse.
- Invalid geometry: Win 5×2 on Frame 4×4 -> `Done` 2 cycles after Start, `Err`=1, no `ALUOp` activity.
- Back-pressure: `SAD_valid` delayed 10 cycles per candidate -> results unchanged; Start during `Busy` ignored.
- Timeout (`SAD_WAIT_TIMEOUT_EN` defined): `SAD_valid` never asserted -> `Done` with `Err`=1 after 256 WAIT cycles.
